// File: rtl/uart_mult_byte_tx.sv
// Fixed 14-byte frame transmitter: head, 11 payload bytes, CRC8 of the payload, tail.
// Each byte is sent 8N1, LSB first; consecutive bytes follow with no idle gap.
module uart_mult_byte_tx #(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          UART_BPS  = 115200,
    parameter logic [7:0]  HEAD_BYTE = 8'h55,
    parameter logic [7:0]  TAIL_BYTE = 8'hAA
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tx_start,
    input  logic [87:0] tx_payload,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [3:0]  byte_idx,
    output logic [7:0]  crc_out
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPS_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
    logic [3:0]       bit_cnt, bit_cnt_next;
    logic [3:0]       byte_idx_next;
    logic             txd_next, busy_next, done_next;
    logic             accept, crc_step, bit_end;
    logic [7:0]       pay_buf [0:10];
    logic [7:0]       crc_acc, crc_new, cur_byte;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign bit_end = (clk_cnt == LAST_CNT);
    assign crc_new = crc8_byte(crc_acc, cur_byte);

    always_comb begin
        cur_byte = TAIL_BYTE;
        if (byte_idx == 4'd0)
            cur_byte = HEAD_BYTE;
        else if (byte_idx <= 4'd11)
            cur_byte = pay_buf[byte_idx - 4'd1];
        else if (byte_idx == 4'd12)
            cur_byte = crc_out;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            clk_cnt  <= clk_cnt_next;
            bit_cnt  <= bit_cnt_next;
            byte_idx <= byte_idx_next;
            uart_txd <= txd_next;
            tx_busy  <= busy_next;
            tx_done  <= done_next;
        end
    end

    // bit_cnt: 0 = start bit, 1..8 = data bits 0..7, 9 = stop bit
    always_comb begin
        state_next    = state;
        clk_cnt_next  = clk_cnt;
        bit_cnt_next  = bit_cnt;
        byte_idx_next = byte_idx;
        txd_next      = uart_txd;
        busy_next     = tx_busy;
        done_next     = 1'b0;
        accept        = 1'b0;
        crc_step      = 1'b0;
        case (state)
            IDLE: begin
                byte_idx_next = 4'd0;
                clk_cnt_next  = '0;
                txd_next      = 1'b1;
                if (tx_start) begin
                    accept       = 1'b1;
                    state_next   = START;
                    bit_cnt_next = 4'd0;
                    txd_next     = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                clk_cnt_next = bit_end ? '0 : clk_cnt + CNT_W'(1);
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = 4'd1;
                    txd_next     = cur_byte[0];
                end
            end
            DATA: begin
                clk_cnt_next = bit_end ? '0 : clk_cnt + CNT_W'(1);
                if (bit_end) begin
                    if (bit_cnt == 4'd8) begin
                        state_next   = STOP;
                        bit_cnt_next = 4'd9;
                        txd_next     = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                        txd_next     = cur_byte[bit_cnt[2:0]];
                    end
                end
            end
            STOP: begin
                clk_cnt_next = bit_end ? '0 : clk_cnt + CNT_W'(1);
                if (bit_end) begin
                    crc_step     = (byte_idx >= 4'd1) && (byte_idx <= 4'd11);
                    bit_cnt_next = 4'd0;
                    if (byte_idx == 4'd13) begin
                        state_next    = IDLE;
                        byte_idx_next = 4'd0;
                        txd_next      = 1'b1;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        state_next    = START;
                        byte_idx_next = byte_idx + 4'd1;
                        txd_next      = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // CRC folds in each payload byte as its stop bit ends, so it is final as byte 12 starts
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            crc_acc <= 8'h00;
            crc_out <= 8'h00;
        end else if (accept) begin
            crc_acc <= 8'h00;
            for (int k = 0; k < 11; k++)
                pay_buf[k] <= tx_payload[8*k +: 8];
        end else if (crc_step) begin
            crc_acc <= crc_new;
            if (byte_idx == 4'd11)
                crc_out <= crc_new;
        end
    end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: records the serial line, decodes it as 8N1 and compares
// against frames built from a long-division CRC model.
module tb_uart_mult_byte_tx;

    localparam int BPS  = 10;
    localparam int MAXW = 3000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        tx_start;
    logic [87:0] tx_payload;
    logic        uart_txd;
    logic        tx_busy;
    logic        tx_done;
    logic [3:0]  byte_idx;
    logic [7:0]  crc_out;

    int tests  = 0;
    int failed = 0;

    logic       line_s [MAXW];
    logic       busy_s [MAXW];
    logic       done_s [MAXW];
    logic [3:0] idx_s  [MAXW];
    int         nsamp;
    logic [7:0] dec_q [$];
    int         done_q [$];
    int         ferr;
    int         busy_cnt;

    uart_mult_byte_tx #(
        .CLK_FREQ(1_000_000),
        .UART_BPS(100_000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_start  (tx_start),
        .tx_payload(tx_payload),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .byte_idx  (byte_idx),
        .crc_out   (crc_out)
    );

    always #5 sys_clk = ~sys_clk;

    // CRC as polynomial long division of the payload bit string (x^8 appended) by 0x107
    function automatic logic [7:0] model_crc(input logic [87:0] p);
        logic [0:95] msg;
        logic [8:0]  poly;
        logic [7:0]  r;
        poly = 9'h107;
        msg  = '0;
        for (int k = 0; k < 11; k++)
            for (int b = 0; b < 8; b++)
                msg[k*8 + b] = p[8*k + 7 - b];
        for (int i = 0; i < 88; i++)
            if (msg[i])
                for (int j = 0; j < 9; j++)
                    msg[i + j] = msg[i + j] ^ poly[8 - j];
        for (int b = 0; b < 8; b++)
            r[7 - b] = msg[88 + b];
        return r;
    endfunction

    function automatic logic [111:0] exp_frame(input logic [87:0] p);
        logic [111:0] v;
        v = {8'hAA, model_crc(p), p, 8'h55};
        return v;
    endfunction

    function automatic logic [111:0] dec_frame(input int off);
        logic [111:0] v;
        for (int k = 0; k < 14; k++)
            v[8*k +: 8] = (off + k < dec_q.size()) ? dec_q[off + k] : 8'hxx;
        return v;
    endfunction

    function automatic logic [87:0] rand_payload();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[87:0];
    endfunction

    // Sample index 0 is the edge that accepts the frame; the value driven after sample c acts at edge c+1
    task automatic run_window(input int ncyc, input logic [87:0] pay, input int hold_last,
                              input int pulse_at, input logic [87:0] alt, input int rst_at);
        @(negedge sys_clk);
        tx_payload = pay;
        tx_start   = 1'b1;
        nsamp      = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge sys_clk);
            line_s[c] = uart_txd;
            busy_s[c] = tx_busy;
            done_s[c] = tx_done;
            idx_s[c]  = byte_idx;
            nsamp++;
            tx_start  = ((c + 1) <= hold_last) || ((c + 1) == pulse_at);
            if ((c + 1) == pulse_at)
                tx_payload = alt;
            sys_rst_n = ((c + 1) == rst_at);
        end
        tx_start  = 1'b0;
        sys_rst_n = 1'b0;
    endtask

    task automatic analyze();
        int i;
        logic [7:0] b;
        dec_q.delete();
        done_q.delete();
        ferr     = 0;
        busy_cnt = 0;
        for (int c = 0; c < nsamp; c++) begin
            if (busy_s[c] === 1'b1) busy_cnt++;
            if (done_s[c] === 1'b1) done_q.push_back(c);
        end
        i = 0;
        while (i + 9*BPS + BPS/2 < nsamp) begin
            if (line_s[i] === 1'b0) begin
                if (line_s[i + BPS/2] !== 1'b0) ferr++;
                for (int n = 0; n < 8; n++)
                    b[n] = line_s[i + (n + 1)*BPS + BPS/2];
                if (line_s[i + 9*BPS + BPS/2] !== 1'b1) ferr++;
                dec_q.push_back(b);
                i = i + 9*BPS + BPS/2;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        int viol;
        sys_rst_n  = 1'b1;
        tx_start   = 1'b0;
        tx_payload = '0;
        repeat (3) @(negedge sys_clk);
        tests++; if (uart_txd !== 1'b1) begin failed++; $display("[TB] FAIL reset_txd: got %b expected 1", uart_txd); end
        tests++; if (tx_busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
        tests++; if (tx_done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done); end
        tests++; if (byte_idx !== 4'd0) begin failed++; $display("[TB] FAIL reset_byte_idx: got %0d expected 0", byte_idx); end
        tests++; if (crc_out !== 8'h00) begin failed++; $display("[TB] FAIL reset_crc: got %h expected 00", crc_out); end
        sys_rst_n = 1'b0;
        viol = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) viol++;
        end
        tests++; if (viol != 0) begin failed++; $display("[TB] FAIL idle_line: got %0d bad clocks expected 0", viol); end
    endtask

    task automatic test_zero_frame();
        int idx_err;
        run_window(1420, 88'h0, 0, -1, 88'h0, -1);
        analyze();
        idx_err = 0;
        for (int c = 0; c < 1400; c++)
            if (idx_s[c] !== 4'(c / 100)) idx_err++;
        tests++; if (dec_q.size() != 14 || ferr != 0) begin failed++; $display("[TB] FAIL zero_count: got %0d bytes %0d framing errors expected 14 and 0", dec_q.size(), ferr); end
        tests++; if (dec_frame(0) !== exp_frame(88'h0)) begin failed++; $display("[TB] FAIL zero_frame: got %h expected %h", dec_frame(0), exp_frame(88'h0)); end
        tests++; if (busy_cnt != 1400) begin failed++; $display("[TB] FAIL zero_busy_len: got %0d expected 1400", busy_cnt); end
        tests++; if (done_q.size() != 1 || done_q[0] != 1400) begin failed++; $display("[TB] FAIL zero_done: got %0d pulses (first at %0d) expected 1 at 1400", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1); end
        tests++; if (idx_err != 0) begin failed++; $display("[TB] FAIL zero_byte_idx: got %0d wrong samples expected 0", idx_err); end
        tests++; if (idx_s[1400] !== 4'd0) begin failed++; $display("[TB] FAIL zero_idx_after: got %0d expected 0", idx_s[1400]); end
    endtask

    task automatic test_crc_vectors();
        logic [87:0] p;
        p = '0;
        for (int k = 2; k <= 10; k++)
            p[8*k +: 8] = 8'h31 + 8'(k - 2);
        run_window(1420, p, 0, -1, 88'h0, -1);
        analyze();
        tests++; if (dec_q.size() < 13 || dec_q[12] !== 8'hF4) begin failed++; $display("[TB] FAIL crc_check_byte: got %h expected f4", (dec_q.size() > 12) ? dec_q[12] : 8'hxx); end
        tests++; if (crc_out !== 8'hF4) begin failed++; $display("[TB] FAIL crc_check_out: got %h expected f4", crc_out); end
        tests++; if (dec_frame(0) !== exp_frame(p)) begin failed++; $display("[TB] FAIL crc_check_frame: got %h expected %h", dec_frame(0), exp_frame(p)); end
        p = '0;
        p[87:80] = 8'h01;
        run_window(1420, p, 0, -1, 88'h0, -1);
        analyze();
        tests++; if (dec_q.size() < 13 || dec_q[12] !== 8'h07) begin failed++; $display("[TB] FAIL crc_one_byte: got %h expected 07", (dec_q.size() > 12) ? dec_q[12] : 8'hxx); end
        tests++; if (crc_out !== 8'h07) begin failed++; $display("[TB] FAIL crc_one_out: got %h expected 07", crc_out); end
    endtask

    task automatic test_start_while_busy();
        logic [87:0] p1, p2;
        p1 = rand_payload();
        p2 = ~p1;
        run_window(1600, p1, 0, 300, p2, -1);
        analyze();
        tests++; if (dec_q.size() != 14 || dec_frame(0) !== exp_frame(p1)) begin failed++; $display("[TB] FAIL busy_drop_frame: got %0d bytes %h expected 14 bytes %h", dec_q.size(), dec_frame(0), exp_frame(p1)); end
        tests++; if (done_q.size() != 1 || busy_cnt != 1400) begin failed++; $display("[TB] FAIL busy_drop_done: got %0d pulses %0d busy clocks expected 1 and 1400", done_q.size(), busy_cnt); end
        tests++; if (crc_out !== model_crc(p1)) begin failed++; $display("[TB] FAIL busy_drop_crc: got %h expected %h", crc_out, model_crc(p1)); end
    endtask

    task automatic test_back_to_back();
        logic [87:0] p;
        p = rand_payload();
        run_window(2900, p, 1500, -1, 88'h0, -1);
        analyze();
        tests++; if (done_q.size() != 2 || done_q[0] != 1400 || done_q[1] != 2801) begin failed++; $display("[TB] FAIL b2b_done: got %0d pulses at %0d,%0d expected 2 at 1400,2801", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, (done_q.size() > 1) ? done_q[1] : -1); end
        tests++; if (busy_cnt != 2800) begin failed++; $display("[TB] FAIL b2b_busy_len: got %0d expected 2800", busy_cnt); end
        tests++; if (dec_q.size() != 28 || dec_frame(0) !== exp_frame(p) || dec_frame(14) !== exp_frame(p)) begin failed++; $display("[TB] FAIL b2b_frames: got %0d bytes %h / %h expected 28 bytes %h", dec_q.size(), dec_frame(0), dec_frame(14), exp_frame(p)); end
    endtask

    task automatic test_reset_mid_frame();
        logic [87:0] p;
        run_window(700, 88'h0, 0, -1, 88'h0, 550);
        analyze();
        tests++; if (line_s[550] !== 1'b1 || busy_s[550] !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid_line: got txd %b busy %b expected 1 and 0", line_s[550], busy_s[550]); end
        tests++; if (done_q.size() != 0 || busy_cnt != 550) begin failed++; $display("[TB] FAIL rst_mid_abort: got %0d pulses %0d busy clocks expected 0 and 550", done_q.size(), busy_cnt); end
        p = rand_payload();
        run_window(1420, p, 0, -1, 88'h0, -1);
        analyze();
        tests++; if (dec_q.size() != 14 || dec_frame(0) !== exp_frame(p) || done_q.size() != 1) begin failed++; $display("[TB] FAIL rst_mid_restart: got %0d bytes %h %0d pulses expected 14 bytes %h 1 pulse", dec_q.size(), dec_frame(0), done_q.size(), exp_frame(p)); end
    endtask

    task automatic test_random_frames();
        logic [87:0] p;
        for (int n = 0; n < 4; n++) begin
            p = rand_payload();
            run_window(1420, p, 0, -1, 88'h0, -1);
            analyze();
            tests++; if (dec_q.size() != 14 || ferr != 0 || dec_frame(0) !== exp_frame(p)) begin failed++; $display("[TB] FAIL rand_frame%0d: got %0d bytes %h expected 14 bytes %h", n, dec_q.size(), dec_frame(0), exp_frame(p)); end
            tests++; if (crc_out !== model_crc(p)) begin failed++; $display("[TB] FAIL rand_crc%0d: got %h expected %h", n, crc_out, model_crc(p)); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_crc_vectors();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
